// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser
//   Assembles SOF / LEN / payload / CHK frames from a UART byte strobe, buffers
//   the payload, validates LEN and the additive checksum, then replays good
//   payloads on a valid/ready byte stream with a last marker. Bad frames and
//   bytes that arrive while a payload is being replayed are reported on
//   frame_err with a reason code.
//
//   Optional feature macro: UART_FRAME_TIMEOUT_EN
//     Defined   -> an idle counter aborts a partial frame after TIMEOUT_CLKS
//                  clocks without a byte (err_code 0).
//     Undefined -> no counter; a partial frame waits indefinitely.
module uart_rx_frame_parser #(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SOF_BYTE     = 8'hA5,
  parameter int         CLOCK_FREQ   = 50000000,
  parameter int         TIMEOUT_CLKS = 104160
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  // Pointer / length width: must hold the value MAX_LEN itself.
  localparam int PW = $clog2(MAX_LEN + 1);
  // Buffer address width: only needs to span 0..MAX_LEN-1.
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  // Reject parameter sets the frame format cannot represent.
  if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
    $error("uart_rx_frame_parser: MAX_LEN must be within 1..255");
  end
  if (CLOCK_FREQ < 1) begin : g_bad_clock_freq
    $error("uart_rx_frame_parser: CLOCK_FREQ must be positive");
  end
  if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
    $error("uart_rx_frame_parser: TIMEOUT_CLKS must be at least 2");
  end

  typedef enum logic [2:0] {
    S_SOF,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_OUT
  } state_t;

  state_t          state_reg;
  logic [PW-1:0]   len_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [7:0]      sum_reg;
  logic [7:0]      m_data_reg;
  logic            m_valid_reg;
  logic            m_last_reg;
  logic            frame_ok_reg;
  logic            frame_err_reg;
  logic [1:0]      err_code_reg;

  logic [7:0]      buf_mem [0:MAX_LEN-1];

  logic [PW-1:0]   wr_ptr_next;
  logic [PW-1:0]   rd_ptr_next;
  logic [AW-1:0]   rd_addr;
  logic [7:0]      buf_rd;
  logic            len_ok;
  logic            buf_we;
  logic            handshake;
  logic            timeout_hit;

  assign wr_ptr_next = wr_ptr_reg + 1'b1;
  assign rd_ptr_next = rd_ptr_reg + 1'b1;
  assign len_ok      = (rx_data != 8'd0) && (rx_data <= MAX_LEN_B);
  assign buf_we      = rx_valid && (state_reg == S_PAYLOAD);
  assign handshake   = m_valid_reg && m_ready;

  // The first byte is fetched while the checksum is accepted; afterwards the
  // following byte is fetched on each transfer so m_data is always registered.
  assign rd_addr = (state_reg == S_OUT) ? rd_ptr_next[AW-1:0] : '0;
  assign buf_rd  = buf_mem[rd_addr];

  // Payload buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[wr_ptr_reg[AW-1:0]] <= rx_data;
    end
  end

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CLKS - 1);

  logic [TW-1:0] idle_cnt_reg;
  logic          in_frame;

  assign in_frame    = (state_reg == S_LEN) || (state_reg == S_PAYLOAD) || (state_reg == S_CHK);
  assign timeout_hit = in_frame && !rx_valid && (idle_cnt_reg == IDLE_LAST);

  // Idle counter: runs only inside a partial frame, cleared by every byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else if (!in_frame || rx_valid || timeout_hit) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame parser and replay FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_SOF;
      len_reg       <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      sum_reg       <= '0;
      m_data_reg    <= '0;
      m_valid_reg   <= 1'b0;
      m_last_reg    <= 1'b0;
      frame_ok_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      err_code_reg  <= 2'd0;
    end else begin
      frame_ok_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        S_SOF: begin
          // Non-SOF bytes are line noise between frames: ignored silently.
          if (rx_valid && (rx_data == SOF_BYTE)) begin
            state_reg <= S_LEN;
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            if (len_ok) begin
              len_reg    <= rx_data[PW-1:0];
              sum_reg    <= rx_data;
              wr_ptr_reg <= '0;
              state_reg  <= S_PAYLOAD;
            end else begin
              // The rejected LEN byte is consumed, never re-read as SOF.
              frame_err_reg <= 1'b1;
              err_code_reg  <= 2'd1;
              state_reg     <= S_SOF;
            end
          end else if (timeout_hit) begin
            frame_err_reg <= 1'b1;
            err_code_reg  <= 2'd0;
            state_reg     <= S_SOF;
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            sum_reg    <= sum_reg + rx_data;
            wr_ptr_reg <= wr_ptr_next;
            if (wr_ptr_next == len_reg) begin
              state_reg <= S_CHK;
            end
          end else if (timeout_hit) begin
            frame_err_reg <= 1'b1;
            err_code_reg  <= 2'd0;
            state_reg     <= S_SOF;
          end
        end
        S_CHK: begin
          if (rx_valid) begin
            if (rx_data == sum_reg) begin
              frame_ok_reg <= 1'b1;
              rd_ptr_reg   <= '0;
              m_valid_reg  <= 1'b1;
              m_data_reg   <= buf_rd;
              m_last_reg   <= (len_reg == PW'(1));
              state_reg    <= S_OUT;
            end else begin
              frame_err_reg <= 1'b1;
              err_code_reg  <= 2'd2;
              state_reg     <= S_SOF;
            end
          end else if (timeout_hit) begin
            frame_err_reg <= 1'b1;
            err_code_reg  <= 2'd0;
            state_reg     <= S_SOF;
          end
        end
        S_OUT: begin
          // No room to hold a new frame while replaying: drop and report.
          if (rx_valid) begin
            frame_err_reg <= 1'b1;
            err_code_reg  <= 2'd3;
          end
          if (handshake) begin
            if (m_last_reg) begin
              m_valid_reg <= 1'b0;
              m_last_reg  <= 1'b0;
              state_reg   <= S_SOF;
            end else begin
              rd_ptr_reg <= rd_ptr_next;
              m_data_reg <= buf_rd;
              m_last_reg <= (rd_ptr_next == (len_reg - PW'(1)));
            end
          end
        end
        default: begin
          state_reg <= S_SOF;
        end
      endcase
    end
  end

  assign m_data    = m_data_reg;
  assign m_valid   = m_valid_reg;
  assign m_last    = m_last_reg;
  assign frame_ok  = frame_ok_reg;
  assign frame_err = frame_err_reg;
  assign err_code  = err_code_reg;
  assign busy      = (state_reg != S_SOF);

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb_uart_rx_frame_parser
//   Scoreboard bench: stimulus pushes expected payload beats and status pulses
//   into queues computed from the frame rules; a negedge monitor pops and
//   compares whenever the DUT transfers a beat or pulses a status output.
//   Build with +define+UART_FRAME_TIMEOUT_EN to exercise the timeout path.
module tb_uart_rx_frame_parser;

  localparam int MAX_LEN      = 16;
  localparam int TIMEOUT_CLKS = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_frame_parser #(
    .MAX_LEN      (MAX_LEN),
    .SOF_BYTE     (8'hA5),
    .CLOCK_FREQ   (50000000),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Expected beats {last, data}; expected status: -1 = frame_ok, 0..3 = err code.
  logic [8:0] exp_beats[$];
  int         exp_status[$];
  int         ready_mode = 0;  // 0 random, 1 held low, 2 held high

  // ---------------- consumer ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = ($urandom_range(0, 3) != 0);
        1:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic       prev_hold;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [1:0] prev_code;
    logic [8:0] eb;
    int         es;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    prev_last = 1'b0;
    prev_code = 2'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        prev_code = 2'd0;
      end else begin
        if (prev_hold) begin
          checks++;
          if (!(m_valid && m_data == prev_data && m_last == prev_last)) begin
            failures++;
            $display("FAIL hold: got valid=%0b data=%02h last=%0b, need valid=1 data=%02h last=%0b",
                     m_valid, m_data, m_last, prev_data, prev_last);
          end
        end
        if (m_valid && m_ready) begin
          checks++;
          if (exp_beats.size() == 0) begin
            failures++;
            $display("FAIL beat: got unexpected data=%02h last=%0b, need no beat", m_data, m_last);
          end else begin
            eb = exp_beats.pop_front();
            if ({m_last, m_data} != eb) begin
              failures++;
              $display("FAIL beat: got data=%02h last=%0b, need data=%02h last=%0b",
                       m_data, m_last, eb[7:0], eb[8]);
            end
          end
        end
        if (frame_ok && frame_err) begin
          checks++;
          failures++;
          $display("FAIL pulse: got frame_ok=1 and frame_err=1 together, need at most one");
        end
        if (frame_ok) begin
          checks++;
          if (exp_status.size() == 0) begin
            failures++;
            $display("FAIL status: got unexpected frame_ok, need none");
          end else begin
            es = exp_status.pop_front();
            if (es != -1) begin
              failures++;
              $display("FAIL status: got frame_ok, need frame_err code %0d", es);
            end else begin
              $display("frame accepted");
            end
          end
          checks++;
          if (!m_valid) begin
            failures++;
            $display("FAIL latency: got m_valid=0 with frame_ok, need m_valid=1");
          end
        end
        if (frame_err) begin
          checks++;
          if (exp_status.size() == 0) begin
            failures++;
            $display("FAIL status: got unexpected frame_err code %0d, need none", err_code);
          end else begin
            es = exp_status.pop_front();
            if (es != int'(err_code)) begin
              failures++;
              $display("FAIL status: got frame_err code %0d, need status %0d (-1 means frame_ok)",
                       err_code, es);
            end else begin
              $display("frame error code %0d", err_code);
            end
          end
        end else begin
          checks++;
          if (err_code != prev_code) begin
            failures++;
            $display("FAIL err_hold: got err_code=%0d without pulse, need %0d", err_code, prev_code);
          end
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
        prev_last = m_last;
        prev_code = err_code;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    idle(gap);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_beats.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_beats.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d beats outstanding after %0d clks, need 0", exp_beats.size(), n);
      exp_beats.delete();
    end
    idle(1);
  endtask

  task automatic wait_status();
    int n;
    n = 0;
    while (exp_status.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_status.size() != 0) begin
      failures++;
      $display("FAIL status_wait: got %0d pulses outstanding, need 0", exp_status.size());
      exp_status.delete();
    end
  endtask

  // Good frame with random payload; checksum = (LEN + sum of payload) mod 256.
  task automatic send_good(input int len, input bit overrun, input int maxgap);
    logic [7:0] pl[$];
    int         total;
    total = len;
    for (int i = 0; i < len; i++) begin
      pl.push_back(8'($urandom));
      total = total + int'(pl[i]);
      exp_beats.push_back({(i == len - 1) ? 1'b1 : 1'b0, pl[i]});
    end
    exp_status.push_back(-1);
    send_byte(8'hA5, $urandom_range(0, maxgap));
    send_byte(8'(len), $urandom_range(0, maxgap));
    for (int i = 0; i < len; i++) send_byte(pl[i], $urandom_range(0, maxgap));
    if (overrun) begin
      send_byte(8'(total % 256), 0);
      exp_status.push_back(3);
      send_byte(8'($urandom), 0);
    end else begin
      send_byte(8'(total % 256), 0);
    end
    wait_drain();
  endtask

  task automatic send_bad_chk(input int len, input int maxgap);
    logic [7:0] pl[$];
    int         total;
    total = len;
    for (int i = 0; i < len; i++) begin
      pl.push_back(8'($urandom));
      total = total + int'(pl[i]);
    end
    exp_status.push_back(2);
    send_byte(8'hA5, $urandom_range(0, maxgap));
    send_byte(8'(len), $urandom_range(0, maxgap));
    for (int i = 0; i < len; i++) send_byte(pl[i], $urandom_range(0, maxgap));
    send_byte(8'((total + $urandom_range(1, 255)) % 256), $urandom_range(0, maxgap));
    wait_status();
  endtask

  task automatic check_busy(input string name, input logic need);
    checks++;
    if (busy !== need) begin
      failures++;
      $display("FAIL %s: got busy=%0b, need %0b", name, busy, need);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({m_data, m_valid, m_last, frame_ok, frame_err, err_code, busy} !== 15'd0) begin
      failures++;
      $display("FAIL %s: got data=%02h valid=%0b last=%0b ok=%0b err=%0b code=%0d busy=%0b, need all 0",
               name, m_data, m_valid, m_last, frame_ok, frame_err, err_code, busy);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish within 5 ms, need finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [7:0] pay[3];
    int         kind;

    #2;
    check_reset_outputs("reset");
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Good frame A5 03 11 22 33 69 with m_ready held high.
    ready_mode = 2;
    idle(2);
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    for (int i = 0; i < 3; i++) exp_beats.push_back({(i == 2) ? 1'b1 : 1'b0, pay[i]});
    exp_status.push_back(-1);
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 3; i++) send_byte(pay[i], 0);
    send_byte(8'h69, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (!(m_valid && m_data == pay[k] && m_last == (k == 2))) begin
        failures++;
        $display("FAIL burst%0d: got valid=%0b data=%02h last=%0b, need valid=1 data=%02h last=%0b",
                 k, m_valid, m_data, m_last, pay[k], (k == 2));
      end
      idle(1);
    end
    wait_drain();

    // Bad checksum.
    exp_status.push_back(2);
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 3; i++) send_byte(pay[i], 0);
    send_byte(8'h68, 0);
    wait_status();

    // Bad lengths 0 and 0x11.
    exp_status.push_back(1);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    check_busy("badlen0_busy", 1'b0);
    exp_status.push_back(1);
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    check_busy("badlen17_busy", 1'b0);
    wait_status();

    // Leading garbage, then a stalled single-byte frame with an overrun byte.
    ready_mode = 1;
    exp_status.push_back(1);
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'hA5, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h7E, 0);
    send_byte(8'h7F, 0);
    wait_status();
    check_busy("garbage_busy", 1'b0);
    exp_beats.push_back({1'b1, 8'h7E});
    exp_status.push_back(-1);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h7E, 0);
    send_byte(8'h7F, 0);
    exp_status.push_back(3);
    send_byte(8'h55, 0);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (!(m_valid && m_data == 8'h7E && m_last)) begin
        failures++;
        $display("FAIL stall%0d: got valid=%0b data=%02h last=%0b, need valid=1 data=7e last=1",
                 k, m_valid, m_data, m_last);
      end
      idle(1);
    end
    ready_mode = 2;
    wait_drain();
    wait_status();
    ready_mode = 0;

    // Reset in the middle of a frame.
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    idle(3);
    rst_n = 1'b1;
    idle(1);
    send_good(3, 1'b0, 1);

    // Partial frame followed by a long silence.
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
`ifdef UART_FRAME_TIMEOUT_EN
    exp_status.push_back(0);
    idle(TIMEOUT_CLKS + 5);
    check_busy("timeout_busy", 1'b0);
    wait_status();
`else
    idle(TIMEOUT_CLKS + 5);
    check_busy("no_timeout_busy", 1'b1);
    exp_beats.push_back({1'b0, 8'h11});
    exp_beats.push_back({1'b1, 8'h22});
    exp_status.push_back(-1);
    send_byte(8'h22, 0);
    send_byte(8'h35, 0);
    wait_drain();
`endif

    // Randomized mix of frames.
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin
          repeat ($urandom_range(1, 4)) begin
            logic [7:0] g;
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g, $urandom_range(0, 2));
          end
        end
        1: begin
          exp_status.push_back(1);
          send_byte(8'hA5, $urandom_range(0, 2));
          if ($urandom_range(0, 1) == 0) send_byte(8'h00, $urandom_range(0, 2));
          else send_byte(8'($urandom_range(MAX_LEN + 1, 255)), $urandom_range(0, 2));
          wait_status();
        end
        2: send_bad_chk($urandom_range(1, MAX_LEN), 2);
        default: send_good($urandom_range(1, MAX_LEN), ($urandom_range(0, 3) == 0), 2);
      endcase
    end

    wait_drain();
    wait_status();
    idle(5);
    checks++;
    if (exp_beats.size() != 0 || exp_status.size() != 0) begin
      failures++;
      $display("FAIL final: got beats=%0d status=%0d outstanding, need 0 0",
               exp_beats.size(), exp_status.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
